// File: rtl/case_5_pkg.sv
// Shared definitions for the case_5 multiplier arbiter.
// Holds the fixed operand/result widths of the shared multiplier, the
// default requester count and tag width, and the round-robin pick function
// used by the top-level arbiter.
package case_5_pkg;

   // Widths of the shared 6s x 5s multiplier instance.
   localparam int A_W = 6;
   localparam int B_W = 5;
   localparam int P_W = 6;

   // Default requester configuration.
   localparam int NUM_REQ_DEF = 4;
   localparam int ID_W_DEF    = 2;

   // Largest supported requester count; rr_pick works on vectors this wide.
   localparam int MAX_REQ   = 8;
   localparam int MAX_REQ_W = 3;

   // Round-robin pick: scan 'valid' starting at index 'ptr', wrapping at
   // 'n', and return a one-hot vector marking the first valid requester.
   // Bits at or above 'n' are always zero. Returns zero when nothing is valid.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0]   valid,
      input logic [MAX_REQ_W-1:0] ptr,
      input logic [MAX_REQ_W:0]   n
   );
      logic [MAX_REQ-1:0] grant;
      logic               found;
      logic [MAX_REQ_W:0] idx;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (i < int'(n)) begin
            idx = {1'b0, ptr} + i[MAX_REQ_W:0];
            if (idx >= n) begin
               idx = idx - n;
            end
            if (!found && valid[idx[MAX_REQ_W-1:0]]) begin
               grant[idx[MAX_REQ_W-1:0]] = 1'b1;
               found = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/case_5_mul_6s_5s_6_1_1.sv
// Combinational signed multiplier, 6-bit signed x 5-bit signed, returning
// the low dout_WIDTH bits of the full-width signed product.
// Ports:
//   din0 : signed operand A (din0_WIDTH bits)
//   din1 : signed operand B (din1_WIDTH bits)
//   dout : truncated signed product (dout_WIDTH bits)
module case_5_mul_6s_5s_6_1_1 #(
   parameter int din0_WIDTH = 6,
   parameter int din1_WIDTH = 5,
   parameter int dout_WIDTH = 6
) (
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout
);

   localparam int FULL_W = din0_WIDTH + din1_WIDTH;

   logic signed [FULL_W-1:0] a_ext;
   logic signed [FULL_W-1:0] b_ext;

   // Sign-extend both operands to the full product width so the multiply
   // is exact before truncation.
   assign a_ext = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
   assign b_ext = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
   assign dout  = dout_WIDTH'(a_ext * b_ext);

endmodule

// File: rtl/case_5_mul_rr_arbiter.sv
// Round-robin front end for one shared combinational signed multiplier.
// NUM_REQ requesters present (a, b) operand pairs with valid/ready; one is
// granted per cycle, its product is registered and returned on a tagged
// response channel with backpressure. A counter tracks consumed responses.
// Ports:
//   ap_clk, ap_rst        : clock, asynchronous active-high reset
//   req_valid / req_ready : per-requester handshake (ready one-hot or zero)
//   req_a, req_b          : packed operands, requester i at [i*W +: W]
//   rsp_valid / rsp_ready : response handshake
//   rsp_id, rsp_data      : requester tag and truncated product
//   op_count              : responses consumed since reset (wraps)
module case_5_mul_rr_arbiter #(
   parameter int NUM_REQ = case_5_pkg::NUM_REQ_DEF,
   parameter int ID_W    = case_5_pkg::ID_W_DEF,
   parameter int A_W     = case_5_pkg::A_W,
   parameter int B_W     = case_5_pkg::B_W,
   parameter int P_W     = case_5_pkg::P_W,
   parameter int CNT_W   = 16
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [P_W-1:0]         rsp_data,
   output logic [CNT_W-1:0]       op_count
);

   import case_5_pkg::*;

   localparam logic [MAX_REQ_W:0] NREQ_L = NUM_REQ[MAX_REQ_W:0];

   logic                 rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]      rsp_id_q,    rsp_id_d;
   logic [P_W-1:0]       rsp_data_q,  rsp_data_d;
   logic [ID_W-1:0]      ptr_q,       ptr_d;
   logic [CNT_W-1:0]     op_count_q,  op_count_d;

   logic [MAX_REQ-1:0]   valid_ext;
   logic [MAX_REQ-1:0]   pick;
   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      gidx;
   logic [A_W-1:0]       a_mux;
   logic [B_W-1:0]       b_mux;
   logic [P_W-1:0]       mul_out;
   logic                 can_accept;
   logic                 fire;
   logic                 consume;

   // Arbitration and operand selection.
   always_comb begin
      valid_ext = '0;
      valid_ext[NUM_REQ-1:0] = req_valid;
      pick  = rr_pick(valid_ext, MAX_REQ_W'(ptr_q), NREQ_L);
      grant = pick[NUM_REQ-1:0];
      gidx  = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (pick[i]) begin
            gidx = ID_W'(i);
         end
      end
      // The grant is one-hot, so OR-ing the masked operands would also work;
      // a priority loop keeps the mux explicit.
      a_mux = '0;
      b_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            a_mux = req_a[i*A_W +: A_W];
            b_mux = req_b[i*B_W +: B_W];
         end
      end
   end

   case_5_mul_6s_5s_6_1_1 #(
      .din0_WIDTH (A_W),
      .din1_WIDTH (B_W),
      .dout_WIDTH (P_W)
   ) u_mul (
      .din0 (a_mux),
      .din1 (b_mux),
      .dout (mul_out)
   );

   // Handshake and next-state logic.
   always_comb begin
      can_accept = !rsp_valid_q || rsp_ready;
      fire       = (|grant) && can_accept;
      consume    = rsp_valid_q && rsp_ready;
      req_ready  = grant & {NUM_REQ{can_accept}};

      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      ptr_d       = ptr_q;
      op_count_d  = op_count_q;

      if (fire) begin
         // A fire in the same cycle as a consume reloads without a bubble.
         rsp_valid_d = 1'b1;
         rsp_id_d    = gidx;
         rsp_data_d  = mul_out;
         ptr_d       = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + ID_W'(1);
      end else if (consume) begin
         // Tag and data deliberately hold their last values.
         rsp_valid_d = 1'b0;
      end

      if (consume) begin
         op_count_d = op_count_q + CNT_W'(1);
      end
   end

   // Response, priority and counter registers.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         ptr_q       <= '0;
         op_count_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         ptr_q       <= ptr_d;
         op_count_q  <= op_count_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign op_count  = op_count_q;

endmodule
